// File: rtl/scfifo_burst_push_arbiter_if.sv
// Push-side bundle between the requesters, the burst arbiter and the FIFO.
// master: requesters plus the FIFO status; slave: the arbiter.
interface scfifo_burst_push_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_W      = 4,
  parameter int CNT_W      = 6
);
  logic [NUM_REQ-1:0]                 iReqValid;
  logic [NUM_REQ-1:0][LEN_W-1:0]      iReqLen;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] iReqData;
  logic [NUM_REQ-1:0]                 iReqDataValid;
  logic [NUM_REQ-1:0]                 oReqDataReady;
  logic [NUM_REQ-1:0]                 oReqGrant;
  logic [NUM_REQ-1:0]                 oReqDone;
  logic [DATA_WIDTH-1:0]              oPushData;
  logic                               oPushEnable;
  logic                               iFifoFull;
  logic [CNT_W-1:0]                   iFifoDataCount;
  logic                               oBusy;

  modport master (
    output iReqValid, iReqLen, iReqData, iReqDataValid, iFifoFull, iFifoDataCount,
    input  oReqDataReady, oReqGrant, oReqDone, oPushData, oPushEnable, oBusy
  );

  modport slave (
    input  iReqValid, iReqLen, iReqData, iReqDataValid, iFifoFull, iFifoDataCount,
    output oReqDataReady, oReqGrant, oReqDone, oPushData, oPushEnable, oBusy
  );
endinterface

// File: rtl/scfifo_burst_push_arbiter.sv
// Round-robin burst arbiter in front of a shared single-clock FIFO push port.
// A burst is only granted when the FIFO has room for every beat of it.

// Per-requester gating: ready, push qualifier and data masking for one lane.
module scfifo_bpa_lane #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  grant,
  input  logic                  fifoFull,
  input  logic                  dataValid,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic                  pushEn,
  output logic [DATA_WIDTH-1:0] dataOut
);
  assign ready   = grant & ~fifoFull;
  assign pushEn  = ready & dataValid;
  assign dataOut = grant ? data : '0;
endmodule

module scfifo_burst_push_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 64,
  parameter int LEN_W      = 4
) (
  input  logic                        iClock,
  input  logic                        iReset,
  scfifo_burst_push_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rrPtr, gIdx, candIdx;
  logic [LEN_W-1:0]   beatCnt;
  logic [NUM_REQ-1:0] grantR, doneR;
  logic               busyR, candValid, fits;
  logic [CNT_W:0]     occ, free;
  logic [LEN_W:0]     needBeats;

  logic [NUM_REQ-1:0]                 laneReady, lanePush;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] laneData;
  logic [DATA_WIDTH-1:0]              pushData;
  logic                               pushEn;

  // Count port wraps to 0 when full, so the full flag supplies the MSB.
  assign occ  = bus.iFifoFull ? DEPTH_V : {1'b0, bus.iFifoDataCount};
  assign free = DEPTH_V - occ;

  // Round-robin candidate: first valid requester at or above rrPtr, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    candValid = 1'b0;
    candIdx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rrPtr) + k) % NUM_REQ;
      if (!candValid && bus.iReqValid[idx]) begin
        candValid = 1'b1;
        candIdx   = IDX_W'(idx);
      end
    end
  end

  // The candidate waits (never skipped) until its whole burst fits.
  assign needBeats = {1'b0, bus.iReqLen[candIdx]} + 1'b1;
  assign fits = ({{(CNT_W+1){1'b0}}, needBeats} <= {{(LEN_W+1){1'b0}}, free});

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : gLane
      scfifo_bpa_lane #(.DATA_WIDTH(DATA_WIDTH)) uLane (
        .grant     (grantR[i]),
        .fifoFull  (bus.iFifoFull),
        .dataValid (bus.iReqDataValid[i]),
        .data      (bus.iReqData[i]),
        .ready     (laneReady[i]),
        .pushEn    (lanePush[i]),
        .dataOut   (laneData[i])
      );
    end
  endgenerate

  // Merge lanes; at most one lane is granted so OR-ing is a mux.
  always_comb begin
    pushData = '0;
    pushEn   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pushData = pushData | laneData[i];
      pushEn   = pushEn | lanePush[i];
    end
  end

  // Arbitration FSM with registered grant/done/busy.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state   <= IDLE;
      rrPtr   <= '0;
      gIdx    <= '0;
      beatCnt <= '0;
      grantR  <= '0;
      doneR   <= '0;
      busyR   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (candValid && fits) begin
          gIdx    <= candIdx;
          beatCnt <= bus.iReqLen[candIdx];
          grantR  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << candIdx;
          busyR   <= 1'b1;
          state   <= BURST;
        end
        BURST: if (pushEn) begin
          if (beatCnt == '0) begin
            doneR  <= grantR;
            grantR <= '0;
            state  <= DONE;
          end else begin
            beatCnt <= beatCnt - 1'b1;
          end
        end
        DONE: begin
          // The idle cycle gives the FIFO count time to include the last push.
          doneR <= '0;
          busyR <= 1'b0;
          rrPtr <= (gIdx == IDX_W'(NUM_REQ-1)) ? '0 : gIdx + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oReqDataReady = laneReady;
  assign bus.oReqGrant     = grantR;
  assign bus.oReqDone      = doneR;
  assign bus.oPushData     = pushData;
  assign bus.oPushEnable   = pushEn;
  assign bus.oBusy         = busyR;
endmodule

// File: tb/tb_scfifo_burst_push_arbiter.sv
// Directed bench for the burst push arbiter: reset, single burst, round robin,
// space reservation, full flag, bubbles/stall, and reset mid-burst.
module tb_scfifo_burst_push_arbiter;
  localparam int NR = 4, DW = 64, LW = 4, CW = 6;

  logic iClock = 1'b0;
  logic iReset = 1'b0;
  int   nCmp = 0, nErr = 0;

  always #5 iClock = ~iClock;

  scfifo_burst_push_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .LEN_W(LW), .CNT_W(CW)) bus ();

  scfifo_burst_push_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .FIFO_DEPTH(64), .LEN_W(LW)) dut (
    .iClock (iClock),
    .iReset (iReset),
    .bus    (bus)
  );

  task step; @(posedge iClock); #1; endtask
  task settle; #1; endtask

  task clearIn;
    bus.iReqValid      = '0;
    bus.iReqLen        = '0;
    bus.iReqData       = '0;
    bus.iReqDataValid  = '0;
    bus.iFifoFull      = 1'b0;
    bus.iFifoDataCount = '0;
  endtask

  task doReset;
    iReset = 1'b0;
    clearIn();
    step(); step();
    iReset = 1'b1;
  endtask

  // Drives requester r's beats (base+n) from the current burst cycle for maxCyc cycles.
  task runBurst(input int r, input logic [63:0] base, input int maxCyc, input logic [15:0] vpat,
                output int pushes, output int dones, output int lastPush, output int doneCyc,
                output int badData, output int otherGrant);
    int beat;
    logic [NR-1:0] mine;
    beat = 0; pushes = 0; dones = 0; lastPush = -1; doneCyc = -1; badData = 0; otherGrant = 0;
    mine = NR'(1) << r;
    for (int c = 0; c < maxCyc; c++) begin
      bus.iReqData[r]      = base + 64'(beat);
      bus.iReqDataValid[r] = vpat[c % 16];
      settle();
      if ((bus.oReqGrant & ~mine) != '0) otherGrant++;
      if (bus.oReqDone[r]) begin dones++; doneCyc = c; end
      if (bus.oPushEnable) begin
        if (bus.oPushData !== base + 64'(beat)) badData++;
        pushes++; beat++; lastPush = c;
      end
      step();
    end
  endtask

  task test_reset;
    iReset = 1'b0;
    bus.iReqValid = '1; bus.iReqDataValid = '1; bus.iReqData = '1;
    bus.iFifoFull = 1'b0; bus.iFifoDataCount = '0; bus.iReqLen = '0;
    settle(); step();
    nCmp++; if (bus.oReqGrant !== 4'b0) begin nErr++; $display("FAIL reset_grant: got %b want 0000", bus.oReqGrant); end
    nCmp++; if (bus.oReqDataReady !== 4'b0) begin nErr++; $display("FAIL reset_ready: got %b want 0000", bus.oReqDataReady); end
    nCmp++; if (bus.oPushEnable !== 1'b0 || bus.oPushData !== 64'h0) begin nErr++; $display("FAIL reset_push: got en=%b data=%h want 0/0", bus.oPushEnable, bus.oPushData); end
    nCmp++; if (bus.oReqDone !== 4'b0 || bus.oBusy !== 1'b0) begin nErr++; $display("FAIL reset_done_busy: got done=%b busy=%b want 0/0", bus.oReqDone, bus.oBusy); end
  endtask

  task test_single_burst;
    int p, d, lp, dc, bd, og;
    doReset();
    bus.iReqValid[0] = 1'b1; bus.iReqLen[0] = 4'd3; bus.iReqDataValid[0] = 1'b1; bus.iReqData[0] = 64'hA0;
    settle();
    nCmp++; if (bus.oReqGrant !== 4'b0) begin nErr++; $display("FAIL single_pregrant: got %b want 0000", bus.oReqGrant); end
    step();
    bus.iReqValid[0] = 1'b0;
    settle();
    nCmp++; if (bus.oReqGrant !== 4'b0001 || bus.oBusy !== 1'b1) begin nErr++; $display("FAIL single_grant: got %b busy=%b want 0001/1", bus.oReqGrant, bus.oBusy); end
    runBurst(0, 64'hA0, 7, 16'hFFFF, p, d, lp, dc, bd, og);
    nCmp++; if (p != 4) begin nErr++; $display("FAIL single_pushes: got %0d want 4", p); end
    nCmp++; if (bd != 0) begin nErr++; $display("FAIL single_data: got %0d bad beats want 0", bd); end
    nCmp++; if (lp != 3 || dc != 4 || d != 1) begin nErr++; $display("FAIL single_done: got last=%0d done@%0d n=%0d want 3/4/1", lp, dc, d); end
    nCmp++; if (bus.oReqGrant !== 4'b0 || bus.oBusy !== 1'b0) begin nErr++; $display("FAIL single_end: got %b busy=%b want 0000/0", bus.oReqGrant, bus.oBusy); end
  endtask

  task test_round_robin;
    int gIdx[$];
    int gCyc[$];
    int overlap;
    logic [NR-1:0] prev;
    overlap = 0; prev = '0;
    iReset = 1'b0; clearIn();
    bus.iReqValid = '1; bus.iReqDataValid = '1;
    for (int i = 0; i < NR; i++) bus.iReqData[i] = 64'h100 + 64'(i);
    step();
    iReset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      settle();
      if ($countones(bus.oReqGrant) > 1) overlap++;
      if (bus.oReqGrant != '0 && prev == '0) begin
        for (int i = 0; i < NR; i++) if (bus.oReqGrant[i]) gIdx.push_back(i);
        gCyc.push_back(c);
      end
      prev = bus.oReqGrant;
      step();
    end
    nCmp++; if (overlap != 0) begin nErr++; $display("FAIL rr_overlap: got %0d want 0", overlap); end
    nCmp++; if (gCyc.size() < 5) begin nErr++; $display("FAIL rr_count: got %0d grants want >=5", gCyc.size()); end
    else begin
      nCmp++; if (gCyc[0] != 1) begin nErr++; $display("FAIL rr_first: got cycle %0d want 1", gCyc[0]); end
      for (int k = 0; k < 5; k++) begin
        nCmp++; if (gIdx[k] != k % NR) begin nErr++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, gIdx[k], k % NR); end
        if (k > 0) begin
          nCmp++; if (gCyc[k] - gCyc[k-1] != 3) begin nErr++; $display("FAIL rr_period[%0d]: got %0d want 3", k, gCyc[k] - gCyc[k-1]); end
        end
      end
    end
  endtask

  task test_space_wait;
    int p, d, lp, dc, bd, og, saw;
    doReset();
    saw = 0;
    bus.iFifoDataCount = 6'd56;
    bus.iReqValid = 4'b0011; bus.iReqLen[0] = 4'd15; bus.iReqLen[1] = 4'd0;
    bus.iReqDataValid = 4'b0011;
    for (int c = 0; c < 5; c++) begin
      settle();
      if (bus.oReqGrant != '0) saw++;
      step();
    end
    nCmp++; if (saw != 0) begin nErr++; $display("FAIL space_wait: got %0d granted cycles want 0", saw); end
    bus.iFifoDataCount = 6'd48;
    step();
    bus.iReqValid[0] = 1'b0;
    settle();
    nCmp++; if (bus.oReqGrant !== 4'b0001) begin nErr++; $display("FAIL space_grant: got %b want 0001", bus.oReqGrant); end
    runBurst(0, 64'hC000, 17, 16'hFFFF, p, d, lp, dc, bd, og);
    nCmp++; if (p != 16 || bd != 0) begin nErr++; $display("FAIL space_pushes: got %0d bad=%0d want 16/0", p, bd); end
    nCmp++; if (og != 0 || d != 1 || lp != 15) begin nErr++; $display("FAIL space_burst: got other=%0d done=%0d last=%0d want 0/1/15", og, d, lp); end
    settle();
    nCmp++; if (bus.oReqGrant !== 4'b0) begin nErr++; $display("FAIL space_idle: got %b want 0000", bus.oReqGrant); end
    step();
    nCmp++; if (bus.oReqGrant !== 4'b0010) begin nErr++; $display("FAIL space_next: got %b want 0010", bus.oReqGrant); end
  endtask

  task test_full_flag;
    int saw;
    doReset();
    saw = 0;
    bus.iFifoFull = 1'b1; bus.iFifoDataCount = 6'd0;
    bus.iReqValid[0] = 1'b1; bus.iReqLen[0] = 4'd15;
    for (int c = 0; c < 4; c++) begin
      settle();
      if (bus.oReqGrant != '0) saw++;
      step();
    end
    nCmp++; if (saw != 0) begin nErr++; $display("FAIL full_nogrant: got %0d granted cycles want 0", saw); end
    bus.iFifoFull = 1'b0;
    step();
    nCmp++; if (bus.oReqGrant !== 4'b0001) begin nErr++; $display("FAIL full_grant64: got %b want 0001", bus.oReqGrant); end
  endtask

  task test_bubbles;
    int p, d, lp, dc, bd, og;
    doReset();
    bus.iReqValid[0] = 1'b1; bus.iReqLen[0] = 4'd3;
    step();
    bus.iReqValid[0] = 1'b0;
    runBurst(0, 64'hB0, 9, 16'h0059, p, d, lp, dc, bd, og);
    nCmp++; if (p != 4 || bd != 0) begin nErr++; $display("FAIL bubble_pushes: got %0d bad=%0d want 4/0", p, bd); end
    nCmp++; if (lp != 6 || dc != 7) begin nErr++; $display("FAIL bubble_done: got last=%0d done@%0d want 6/7", lp, dc); end
    // Full asserted mid-burst stalls the beat.
    doReset();
    bus.iReqValid[0] = 1'b1; bus.iReqLen[0] = 4'd1;
    step();
    bus.iReqValid[0] = 1'b0;
    bus.iFifoFull = 1'b1; bus.iReqDataValid[0] = 1'b1; bus.iReqData[0] = 64'hE0;
    settle();
    nCmp++; if (bus.oReqDataReady !== 4'b0 || bus.oPushEnable !== 1'b0) begin nErr++; $display("FAIL stall_full: got ready=%b push=%b want 0000/0", bus.oReqDataReady, bus.oPushEnable); end
    nCmp++; if (bus.oReqGrant !== 4'b0001) begin nErr++; $display("FAIL stall_grant: got %b want 0001", bus.oReqGrant); end
    step();
    bus.iFifoFull = 1'b0;
    runBurst(0, 64'hE0, 4, 16'hFFFF, p, d, lp, dc, bd, og);
    nCmp++; if (p != 2 || bd != 0 || dc != 2) begin nErr++; $display("FAIL stall_resume: got %0d bad=%0d done@%0d want 2/0/2", p, bd, dc); end
  endtask

  task test_reset_mid_burst;
    int p, d, lp, dc, bd, og;
    doReset();
    bus.iReqValid[1] = 1'b1; bus.iReqLen[1] = 4'd0;
    step();
    bus.iReqValid[1] = 1'b0;
    runBurst(1, 64'h10, 3, 16'hFFFF, p, d, lp, dc, bd, og);
    bus.iReqValid[2] = 1'b1; bus.iReqLen[2] = 4'd3;
    step();
    bus.iReqValid[2] = 1'b0;
    settle();
    nCmp++; if (bus.oReqGrant !== 4'b0100) begin nErr++; $display("FAIL rst_pre_grant: got %b want 0100", bus.oReqGrant); end
    runBurst(2, 64'hD0, 2, 16'hFFFF, p, d, lp, dc, bd, og);
    nCmp++; if (p != 2) begin nErr++; $display("FAIL rst_pre_pushes: got %0d want 2", p); end
    iReset = 1'b0;
    #1;
    nCmp++; if (bus.oReqGrant !== 4'b0 || bus.oReqDataReady !== 4'b0) begin nErr++; $display("FAIL rst_async_grant: got %b ready=%b want 0000/0000", bus.oReqGrant, bus.oReqDataReady); end
    nCmp++; if (bus.oPushEnable !== 1'b0 || bus.oPushData !== 64'h0) begin nErr++; $display("FAIL rst_async_push: got en=%b data=%h want 0/0", bus.oPushEnable, bus.oPushData); end
    nCmp++; if (bus.oBusy !== 1'b0 || bus.oReqDone !== 4'b0) begin nErr++; $display("FAIL rst_async_busy: got busy=%b done=%b want 0/0000", bus.oBusy, bus.oReqDone); end
    step();
    iReset = 1'b1;
    clearIn();
    bus.iReqValid = 4'b1010; bus.iReqDataValid = 4'b1010;
    settle();
    nCmp++; if (bus.oReqGrant !== 4'b0) begin nErr++; $display("FAIL rst_idle: got %b want 0000", bus.oReqGrant); end
    step();
    nCmp++; if (bus.oReqGrant !== 4'b0010) begin nErr++; $display("FAIL rst_rr0: got %b want 0010", bus.oReqGrant); end
  endtask

  initial begin
    clearIn();
    test_reset();
    test_single_burst();
    test_round_robin();
    test_space_wait();
    test_full_flag();
    test_bubbles();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
